// File: rtl/acq_peak_search_ctrl.sv
// Acquisition peak search sequencer: running max/index over a magnitude stream, then threshold decision.
// Optional SECOND_PEAK_EN adds a non-adjacent second-peak tracker (o_second_val/o_second_idx).
module acq_peak_search_ctrl #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned BIN_COUNT  = 4096,
  localparam int unsigned IDX_W      = $clog2(BIN_COUNT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH:0]   i_threshold,
  input  logic [DATA_WIDTH:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH:0]   o_peak_val,
  output logic [IDX_W-1:0]      o_peak_idx,
  output logic                  o_detect,
  output logic                  o_len_err
`ifdef SECOND_PEAK_EN
  ,
  output logic [DATA_WIDTH:0]   o_second_val,
  output logic [IDX_W-1:0]      o_second_idx
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, DECIDE, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH:0]   max_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      count_q;
  logic [DATA_WIDTH:0]   thr_q;
  logic                  len_err_q;
  logic                  beat;
  logic                  last_bin;

  assign beat     = s_axis_tvalid & s_axis_tready;
  assign last_bin = (count_q == IDX_W'(BIN_COUNT - 1));

`ifdef SECOND_PEAK_EN
  logic [DATA_WIDTH:0]   sec_val_q;
  logic [IDX_W-1:0]      sec_idx_q;
  logic [IDX_W-1:0]      peak_dist;
  logic                  far_from_peak;

  always_comb begin
    peak_dist     = (count_q >= idx_q) ? (count_q - idx_q) : (idx_q - count_q);
    far_from_peak = (peak_dist > IDX_W'(1));
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      max_q         <= '0;
      idx_q         <= '0;
      count_q       <= '0;
      thr_q         <= '0;
      len_err_q     <= 1'b0;
      s_axis_tready <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_peak_val    <= '0;
      o_peak_idx    <= '0;
      o_detect      <= 1'b0;
      o_len_err     <= 1'b0;
`ifdef SECOND_PEAK_EN
      sec_val_q     <= '0;
      sec_idx_q     <= '0;
      o_second_val  <= '0;
      o_second_idx  <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state         <= SEARCH;
            max_q         <= '0;
            idx_q         <= '0;
            count_q       <= '0;
            thr_q         <= i_threshold;
            len_err_q     <= 1'b0;
            s_axis_tready <= 1'b1;
            o_busy        <= 1'b1;
            o_peak_val    <= '0;
            o_peak_idx    <= '0;
            o_detect      <= 1'b0;
            o_len_err     <= 1'b0;
`ifdef SECOND_PEAK_EN
            sec_val_q     <= '0;
            sec_idx_q     <= '0;
            o_second_val  <= '0;
            o_second_idx  <= '0;
`endif
          end
        end
        SEARCH: begin
          if (beat) begin
            if (s_axis_tdata > max_q) begin
              max_q <= s_axis_tdata;
              idx_q <= count_q;
`ifdef SECOND_PEAK_EN
              // The displaced peak becomes second only if it is not a neighbour of the new one.
              if (far_from_peak) begin
                sec_val_q <= max_q;
                sec_idx_q <= idx_q;
              end
            end else if ((s_axis_tdata > sec_val_q) && far_from_peak) begin
              sec_val_q <= s_axis_tdata;
              sec_idx_q <= count_q;
`endif
            end
            if (!last_bin)
              count_q <= count_q + IDX_W'(1);
            if (s_axis_tlast || last_bin) begin
              // Exactly one of the two end conditions alone means a length mismatch.
              len_err_q     <= (s_axis_tlast != last_bin);
              s_axis_tready <= 1'b0;
              state         <= DECIDE;
            end
          end
        end
        DECIDE: begin
          o_peak_val <= max_q;
          o_peak_idx <= idx_q;
          o_detect   <= (max_q > thr_q);
          o_len_err  <= len_err_q;
`ifdef SECOND_PEAK_EN
          o_second_val <= sec_val_q;
          o_second_idx <= sec_idx_q;
`endif
          o_busy     <= 1'b0;
          o_done     <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_peak_search_ctrl.sv
// Directed self-checking bench for acq_peak_search_ctrl with BIN_COUNT=8.
module tb_acq_peak_search_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned BINS  = 8;
  localparam int unsigned IDX_W = $clog2(BINS);

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic [DW:0]       i_threshold;
  logic [DW:0]       s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              o_busy;
  logic              o_done;
  logic [DW:0]       o_peak_val;
  logic [IDX_W-1:0]  o_peak_idx;
  logic              o_detect;
  logic              o_len_err;
`ifdef SECOND_PEAK_EN
  logic [DW:0]       o_second_val;
  logic [IDX_W-1:0]  o_second_idx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  acq_peak_search_ctrl #(.DATA_WIDTH(DW), .BIN_COUNT(BINS)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_threshold   (i_threshold),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_peak_val    (o_peak_val),
    .o_peak_idx    (o_peak_idx),
    .o_detect      (o_detect),
    .o_len_err     (o_len_err)
`ifdef SECOND_PEAK_EN
    ,
    .o_second_val  (o_second_val),
    .o_second_idx  (o_second_idx)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic [DW:0] thr);
    i_threshold = thr;
    i_start     = 1'b1;
    step();
    i_start     = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [DW:0] d, input logic l);
    logic acc;
    int   n;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      acc = s_axis_tready;
      step();
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $error("FAIL beat_accept_timeout: observed tready 0 expected 1");
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  initial begin
    logic [DW:0] t1 [8];
    t1 = '{3, 9, 120, 7, 120, 4, 2, 1};
    i_rst = 1'b1; i_start = 1'b0; i_threshold = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    step(); step();
    chk("rst_tready", 64'(s_axis_tready), 0);
    chk("rst_busy",   64'(o_busy), 0);
    chk("rst_done",   64'(o_done), 0);
    chk("rst_val",    64'(o_peak_val), 0);
    chk("rst_idx",    64'(o_peak_idx), 0);
    chk("rst_detect", 64'(o_detect), 0);
    chk("rst_lenerr", 64'(o_len_err), 0);
    i_rst = 1'b0;
    step();

    // T1: tie at 120 keeps bin 2, 120 > 50 detects
    start(50);
    chk("t1_tready", 64'(s_axis_tready), 1);
    chk("t1_busy",   64'(o_busy), 1);
    for (int i = 0; i < 8; i++) send(t1[i], i == 7);
    chk("t1_decide_done",   64'(o_done), 0);
    chk("t1_decide_tready", 64'(s_axis_tready), 0);
    chk("t1_decide_busy",   64'(o_busy), 1);
    step();
    chk("t1_done",   64'(o_done), 1);
    chk("t1_busy",   64'(o_busy), 0);
    chk("t1_val",    64'(o_peak_val), 120);
    chk("t1_idx",    64'(o_peak_idx), 2);
    chk("t1_detect", 64'(o_detect), 1);
    chk("t1_lenerr", 64'(o_len_err), 0);
    step();
    chk("t1_done_pulse", 64'(o_done), 0);
    chk("t1_val_hold",   64'(o_peak_val), 120);

    // T2: threshold equal to peak gives no detect
    start(120);
    for (int i = 0; i < 8; i++) send(t1[i], i == 7);
    step();
    chk("t2_done",   64'(o_done), 1);
    chk("t2_val",    64'(o_peak_val), 120);
    chk("t2_detect", 64'(o_detect), 0);
    step();

    // T3: early tlast after 6 beats; mid-search i_start and threshold change ignored
    start(100);
    i_threshold = 0;
    send(10, 0); send(20, 0);
    i_start = 1'b1;
    send(5, 0);
    i_start = 1'b0;
    send(40, 0); send(60, 0); send(15, 1);
    step();
    chk("t3_done",   64'(o_done), 1);
    chk("t3_val",    64'(o_peak_val), 60);
    chk("t3_idx",    64'(o_peak_idx), 4);
    chk("t3_detect", 64'(o_detect), 0);
    chk("t3_lenerr", 64'(o_len_err), 1);
    step();

    // T3b: 8 beats without tlast ends search with len_err, further beats stall
    start(100);
    for (int i = 0; i < 8; i++) send(DW'(i + 1), 0);
    chk("t3b_tready", 64'(s_axis_tready), 0);
    step();
    chk("t3b_done",   64'(o_done), 1);
    chk("t3b_val",    64'(o_peak_val), 8);
    chk("t3b_idx",    64'(o_peak_idx), 7);
    chk("t3b_lenerr", 64'(o_len_err), 1);
    step();
    chk("t3b_idle_tready", 64'(s_axis_tready), 0);

    // T4: gapped all-zero stream; start must clear previous results
    start(0);
    chk("t4_clear_val",    64'(o_peak_val), 0);
    chk("t4_clear_idx",    64'(o_peak_idx), 0);
    chk("t4_clear_lenerr", 64'(o_len_err), 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      send(0, i == 7);
    end
    chk("t4_done_early", 64'(o_done), 0);
    step();
    chk("t4_done",   64'(o_done), 1);
    chk("t4_val",    64'(o_peak_val), 0);
    chk("t4_idx",    64'(o_peak_idx), 0);
    chk("t4_detect", 64'(o_detect), 0);
    step();

    // T5: asynchronous reset mid-search, then a clean search
    start(1);
    send(50, 0); send(60, 0); send(70, 0); send(80, 0);
    i_rst = 1'b1;
    #2;
    chk("t5_rst_tready", 64'(s_axis_tready), 0);
    chk("t5_rst_busy",   64'(o_busy), 0);
    step();
    i_rst = 1'b0;
    step(); step();
    chk("t5_no_done", 64'(o_done), 0);
    chk("t5_rst_val", 64'(o_peak_val), 0);
    start(3);
    for (int i = 0; i < 8; i++) send(4, i == 7);
    step();
    chk("t5_done",   64'(o_done), 1);
    chk("t5_val",    64'(o_peak_val), 4);
    chk("t5_idx",    64'(o_peak_idx), 0);
    chk("t5_detect", 64'(o_detect), 1);
    step();

`ifdef SECOND_PEAK_EN
    begin
      logic [DW:0] t6 [8];
      t6 = '{5, 100, 90, 10, 60, 0, 0, 0};
      start(0);
      for (int i = 0; i < 8; i++) send(t6[i], i == 7);
      step();
      chk("t6_done",    64'(o_done), 1);
      chk("t6_val",     64'(o_peak_val), 100);
      chk("t6_idx",     64'(o_peak_idx), 1);
      chk("t6_sec_val", 64'(o_second_val), 60);
      chk("t6_sec_idx", 64'(o_second_idx), 4);
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
